frame_rect_writer: RTL and testbench

//  Write side of the 640x480 8-bit-index frame buffer that the VGA scan-out path reads.

---
 rtl/frame_rect_writer.sv | 170 +++++++++++++++++
 tb/tb_frame_rect_writer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_rect_writer.sv
// rtl/frame_rect_writer.sv - rectangle-fill write engine for the 640x480 8-bit frame buffer
// Clips a fill command to the visible area and streams one granted write beat per pixel.
module frame_rect_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iStart,
  input  logic [9:0]        iX0,
  input  logic [8:0]        iY0,
  input  logic [9:0]        iW,
  input  logic [8:0]        iH,
  input  logic [DATA_W-1:0] iColor,
  input  logic              iAbort,
  input  logic              iWrGnt,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [DATA_W-1:0] oWrData,
  output logic              oBusy,
  output logic              oDone
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [9:0]          x0_q, x0_d, w_q, w_d, w_eff_q, w_eff_d, col_q, col_d;
  logic [8:0]          y0_q, y0_d, h_q, h_d, h_eff_q, h_eff_d, row_q, row_d;
  logic [ADDR_W-1:0]   row_start_q, row_start_d, addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;

  logic [9:0]          x_lim, w_clip;
  logic [8:0]          y_lim, h_clip;
  logic                empty;
  logic [ADDR_W-1:0]   base;

  // Clipping is only meaningful when the origin is on-screen; empty covers the rest.
  assign x_lim  = 10'(H_RES) - x0_q;
  assign y_lim  = 9'(V_RES) - y0_q;
  assign w_clip = (w_q < x_lim) ? w_q : x_lim;
  assign h_clip = (h_q < y_lim) ? h_q : y_lim;
  assign empty  = (x0_q >= 10'(H_RES)) || (y0_q >= 9'(V_RES)) || (w_q == '0) || (h_q == '0);
  assign base   = ADDR_W'(y0_q) * ADDR_W'(H_RES) + ADDR_W'(x0_q);

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      w_eff_q     <= '0;
      h_eff_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_start_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      w_eff_q     <= w_eff_d;
      h_eff_q     <= h_eff_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_start_q <= row_start_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    w_eff_d     = w_eff_q;
    h_eff_d     = h_eff_q;
    col_d       = col_q;
    row_d       = row_q;
    row_start_d = row_start_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_en_d     = wr_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
        if (iStart) begin
          x0_d    = iX0;
          y0_d    = iY0;
          w_d     = iW;
          h_d     = iH;
          data_d  = iColor;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (iAbort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (empty) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          w_eff_d     = w_clip;
          h_eff_d     = h_clip;
          col_d       = '0;
          row_d       = '0;
          row_start_d = base;
          addr_d      = base;
          wr_en_d     = 1'b1;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (iAbort) begin
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (iWrGnt) begin
          if (col_q == w_eff_q - 10'd1) begin
            if (row_q == h_eff_q - 9'd1) begin
              wr_en_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              col_d       = '0;
              row_d       = row_q + 9'd1;
              row_start_d = row_start_q + ADDR_W'(H_RES);
              addr_d      = row_start_q + ADDR_W'(H_RES);
            end
          end else begin
            col_d  = col_q + 10'd1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oWrEn   = wr_en_q;
  assign oWrAddr = addr_q;
  assign oWrData = data_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;

endmodule

// File: tb/tb_frame_rect_writer.sv
// tb/tb_frame_rect_writer.sv - directed self-checking bench for frame_rect_writer
// Each command is run cycle by cycle while beats, stalls and oDone timing are recorded.
module tb_frame_rect_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort_s, gnt;
  logic [9:0]  x0, w;
  logic [8:0]  y0, h;
  logic [7:0]  color;
  logic        wr_en, busy, done;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  frame_rect_writer dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iStart(start), .iX0(x0), .iY0(y0),
    .iW(w), .iH(h), .iColor(color), .iAbort(abort_s), .iWrGnt(gnt),
    .oWrEn(wr_en), .oWrAddr(wr_addr), .oWrData(wr_data), .oBusy(busy), .oDone(done)
  );

  int checks = 0;
  int errors = 0;

  int beats, first_addr, probe_addr, last_addr, max_addr, data_err, stall_err;
  int done_cnt, done_cyc, last_gnt_cyc, first_en_cyc, abort_cyc, busy1, timeout;
  int beat_addr[8];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input int cx0, input int cy0, input int cw, input int ch,
                         input logic [7:0] c, input bit alt, input int abort_at,
                         input int junk_at, input int probe_idx, input int budget);
    int cyc;
    logic        stall_pend;
    logic [18:0] stall_addr;
    logic [7:0]  stall_data;
    x0 = cx0[9:0]; y0 = cy0[8:0]; w = cw[9:0]; h = ch[8:0]; color = c;
    start = 1'b1;
    step();
    start = 1'b0;
    busy1 = busy;
    beats = 0; first_addr = -1; probe_addr = -1; last_addr = -1; max_addr = -1;
    data_err = 0; stall_err = 0; done_cnt = 0; done_cyc = -1; last_gnt_cyc = -1;
    first_en_cyc = -1; abort_cyc = -1; timeout = 0; stall_pend = 1'b0;
    stall_addr = '0; stall_data = '0;
    for (int i = 0; i < 8; i++) beat_addr[i] = -1;
    cyc = 1;
    while (1) begin
      if (cyc >= budget) begin timeout = 1; break; end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (abort_cyc >= 0 && cyc >= abort_cyc + 4) break;
      if (wr_en && first_en_cyc < 0) first_en_cyc = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (stall_pend && (wr_addr !== stall_addr || wr_data !== stall_data)) stall_err++;
      gnt = alt ? (cyc % 2 == 0) : 1'b1;
      abort_s = (abort_at >= 0 && abort_cyc < 0 && wr_en && beats == abort_at);
      if (abort_s) abort_cyc = cyc;
      if (cyc == junk_at) begin
        start = 1'b1; x0 = 10'd0; color = ~c;
      end else begin
        start = 1'b0;
      end
      if (wr_en && gnt) begin
        if (beats < 8) beat_addr[beats] = int'(wr_addr);
        if (beats == 0) first_addr = int'(wr_addr);
        if (beats == probe_idx) probe_addr = int'(wr_addr);
        last_addr = int'(wr_addr);
        if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
        if (wr_data !== c) data_err++;
        beats++;
        last_gnt_cyc = cyc;
      end
      stall_pend = wr_en && !gnt;
      stall_addr = wr_addr;
      stall_data = wr_data;
      step();
      cyc++;
    end
    gnt = 1'b0; abort_s = 1'b0; start = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; abort_s = 1'b0; gnt = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    step(); step();
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", wr_addr, 0);
    rst_n = 1'b1;
    step();

    // T1: full-rate fill
    run_cmd(154, 198, 39, 49, 8'h64, 1'b0, -1, -1, 39, 3000);
    check("t1_timeout", timeout, 0);
    check("t1_busy_n1", busy1, 1);
    check("t1_first_en", first_en_cyc, 2);
    check("t1_beats", beats, 1911);
    check("t1_first", first_addr, 126874);
    check("t1_row2", probe_addr, 127514);
    check("t1_last", last_addr, 157632);
    check("t1_max", max_addr, 157632);
    check("t1_data", data_err, 0);
    check("t1_done_lat", done_cyc - last_gnt_cyc, 1);
    check("t1_done_cnt", done_cnt, 1);

    // T2: clipped at bottom-right corner
    run_cmd(630, 470, 20, 20, 8'hA5, 1'b0, -1, -1, 10, 400);
    check("t2_timeout", timeout, 0);
    check("t2_beats", beats, 100);
    check("t2_first", first_addr, 301430);
    check("t2_row2", probe_addr, 301430 + 640);
    check("t2_last", last_addr, 307199);
    check("t2_max", max_addr, 307199);
    check("t2_done_cnt", done_cnt, 1);

    // T3: empty commands
    run_cmd(10, 10, 0, 5, 8'h01, 1'b0, -1, -1, 0, 50);
    check("t3a_beats", beats, 0);
    check("t3a_no_en", first_en_cyc, -1);
    check("t3a_done_cyc", done_cyc, 2);
    check("t3a_done_cnt", done_cnt, 1);
    run_cmd(640, 10, 5, 5, 8'h02, 1'b0, -1, -1, 0, 50);
    check("t3b_beats", beats, 0);
    check("t3b_no_en", first_en_cyc, -1);
    check("t3b_done_cyc", done_cyc, 2);
    run_cmd(10, 480, 5, 5, 8'h03, 1'b0, -1, -1, 0, 50);
    check("t3c_beats", beats, 0);
    check("t3c_done_cyc", done_cyc, 2);

    // T4: one-column rectangle with a stalling grant
    run_cmd(0, 0, 1, 3, 8'h3C, 1'b1, -1, -1, 1, 50);
    check("t4_timeout", timeout, 0);
    check("t4_beats", beats, 3);
    check("t4_addr0", beat_addr[0], 0);
    check("t4_addr1", beat_addr[1], 640);
    check("t4_addr2", beat_addr[2], 1280);
    check("t4_stall", stall_err, 0);
    check("t4_data", data_err, 0);
    check("t4_done_lat", done_cyc - last_gnt_cyc, 1);

    // T5: abort granted with the fifth beat, stray iStart while busy
    run_cmd(100, 100, 10, 10, 8'h5A, 1'b0, 4, 3, 4, 200);
    check("t5_timeout", timeout, 0);
    check("t5_beats", beats, 5);
    check("t5_done_cnt", done_cnt, 0);
    check("t5_last", last_addr, 64104);
    check("t5_data", data_err, 0);
    check("t5_busy_after", busy, 0);
    check("t5_en_after", wr_en, 0);
    run_cmd(0, 0, 2, 2, 8'h11, 1'b0, -1, -1, 2, 50);
    check("t5_restart_beats", beats, 4);
    check("t5_restart_row2", probe_addr, 640);
    check("t5_restart_done", done_cnt, 1);

    // T6: reset mid-WRITE
    x0 = 10'd5; y0 = 9'd5; w = 10'd10; h = 9'd10; color = 8'hEE; gnt = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t6_pre_en", wr_en, 1);
    rst_n = 1'b0;
    step();
    check("t6_rst_en", wr_en, 0);
    check("t6_rst_addr", wr_addr, 0);
    check("t6_rst_data", wr_data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wr_en || done || busy) cnt++;
    end
    check("t6_quiet", cnt, 0);
    gnt = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
